// File: rtl/phys_free_list.sv
// Circular FIFO of free physical register tags feeding rename; releases pushed at commit.
// Grant is combinational off the show-ahead head; pop and push take effect on the clock edge.
module phys_free_list #(
    parameter int  NUM_ARCH_REGS = 35,
    parameter int  NUM_PHYS_REGS = 64,
    localparam int LOG_PHYS      = $clog2(NUM_PHYS_REGS)
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                Alloc_req,
    output logic                Alloc_grant,
    output logic [LOG_PHYS-1:0] Alloc_reg,
    input  logic                Free_req,
    input  logic [LOG_PHYS-1:0] Free_reg,
    output logic [LOG_PHYS:0]   Count,
    output logic                Empty,
    output logic                Full,
    output logic                Err_dbl_free,
    output logic                Err_overflow
);
    localparam int DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [LOG_PHYS-1:0]      tags [DEPTH];
    logic [PTR_W-1:0]         head;
    logic [PTR_W-1:0]         tail;
    logic [LOG_PHYS:0]        cnt;
    logic [NUM_PHYS_REGS-1:0] bitmap;
    logic                     err_dbl;
    logic                     err_ovf;

    logic                     in_range;
    logic                     already_free;
    logic                     accept;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign Empty        = (cnt == '0);
    assign Full         = (cnt == (LOG_PHYS+1)'(DEPTH));
    assign Alloc_reg    = tags[head];
    assign Alloc_grant  = Alloc_req & ~Empty;
    assign Count        = cnt;
    assign Err_dbl_free = err_dbl;
    assign Err_overflow = err_ovf;

    // Range is checked before the bitmap lookup so an out-of-range tag never indexes it.
    assign in_range     = (int'(Free_reg) < NUM_PHYS_REGS);
    assign already_free = in_range ? bitmap[Free_reg] : 1'b0;
    assign accept       = Free_req & ~Full & in_range & ~already_free;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < DEPTH; i++)
                tags[i] <= LOG_PHYS'(NUM_ARCH_REGS + i);
            for (int t = 0; t < NUM_PHYS_REGS; t++)
                bitmap[t] <= (t >= NUM_ARCH_REGS);
            head    <= '0;
            tail    <= '0;
            cnt     <= (LOG_PHYS+1)'(DEPTH);
            err_dbl <= 1'b0;
            err_ovf <= 1'b0;
        end else begin
            if (Alloc_grant) begin
                head              <= ptr_next(head);
                bitmap[Alloc_reg] <= 1'b0;
            end
            // A granted tag still has its bit set, so accept never targets the same bit.
            if (accept) begin
                tags[tail]       <= Free_reg;
                tail             <= ptr_next(tail);
                bitmap[Free_reg] <= 1'b1;
            end
            case ({accept, Alloc_grant})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (Free_req && !accept) begin
                if (Full || !in_range)
                    err_ovf <= 1'b1;
                else
                    err_dbl <= 1'b1;
            end
        end
    end
endmodule
